bcd_subtractor_serial: RTL

- Digit-serial BCD subtractor; the inverse operation of the team's 2-digit BCD adder path.
- Computes DIFF = A − B − bin over DIGITS packed BCD digits, one digit per clock, LSD first, using a borrow chain.
- Start/busy/done handshake; registered results drive the existing hex decoders and LEDs on the lab board.

---
 rtl/bcd_subtractor_serial.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_subtractor_serial.sv
// ---------------------------------------------------------------------------
// bcd_subtractor_serial
//
// Digit-serial packed-BCD subtractor: DIFF = A - B - bin over DIGITS digits.
// It processes one digit per clock, least significant digit first, and
// carries a borrow from each digit into the next.
//
// Optional build macro: BCD_SUB_SIGN_MAG_EN
//   defined   : a negative result gets a second pass that computes
//               0 - result, so diff_bcd holds the magnitude and bout
//               holds the sign.
//   undefined : a negative result stays in 10's-complement form.
//
// Parameters:
//   DIGITS    number of BCD digits per operand (1..8)
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-high
//   start     operation request, sampled only in IDLE
//   a_bcd     minuend, packed BCD, digit 0 in bits [3:0]
//   b_bcd     subtrahend, packed BCD
//   bin       borrow into digit 0
//   diff_bcd  registered result, packed BCD
//   bout      final borrow (1 = result negative)
//   busy      high while an operation is in progress
//   done      one-cycle pulse when diff_bcd/bout/error are updated
//   error     an input digit was > 9 in the last operation
// ---------------------------------------------------------------------------
module bcd_subtractor_serial #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a_bcd,
    input  logic [4*DIGITS-1:0] b_bcd,
    input  logic                bin,
    output logic [4*DIGITS-1:0] diff_bcd,
    output logic                bout,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

`ifdef BCD_SUB_SIGN_MAG_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUB    = 2'd1,
        NEG    = 2'd2,
        FINISH = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUB    = 2'd1,
        FINISH = 2'd2
    } state_t;
`endif

    state_t state;
    state_t state_next;

    // Working registers. Operands shift right so the digit being processed
    // is always in bits [3:0].
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  res_reg;
    logic          borrow_reg;
    logic          err_reg;
    logic [CW-1:0] cnt;
`ifdef BCD_SUB_SIGN_MAG_EN
    logic          neg_reg;
`endif

    // Single-digit datapath, shared by the SUB pass and the NEG pass.
    logic [4:0]   t;
    logic         digit_borrow;
    logic [3:0]   digit_val;
    logic [W-1:0] res_next;
    logic         last_digit;
    logic         inputs_bad;

    // Any digit of either operand outside 0..9 makes the operation invalid.
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    always_comb begin
        // NOTE: every signal written here is assigned before any branch, so
        // no path leaves a value unassigned and no latch is inferred.
        t            = {1'b0, a_reg[3:0]} - {1'b0, b_reg[3:0]} - {4'd0, borrow_reg};
        digit_borrow = t[4];
        // A negative 5-bit t wraps correctly: (t mod 16) + 10 mod 16 = t + 10.
        digit_val    = digit_borrow ? (t[3:0] + 4'd10) : t[3:0];
        // New digit enters at the MSD end; after DIGITS shifts digit 0 sits
        // at bits [3:0].
        res_next     = (res_reg >> 4) | (W'(digit_val) << (W - 4));
        last_digit   = (cnt == LAST_CNT);
        inputs_bad   = has_bad_digit(a_bcd) | has_bad_digit(b_bcd);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = inputs_bad ? FINISH : SUB;
                end
            end
            SUB: begin
                if (last_digit) begin
`ifdef BCD_SUB_SIGN_MAG_EN
                    state_next = digit_borrow ? NEG : FINISH;
`else
                    state_next = FINISH;
`endif
                end
            end
`ifdef BCD_SUB_SIGN_MAG_EN
            NEG: begin
                if (last_digit) begin
                    state_next = FINISH;
                end
            end
`endif
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the operand and working registers are reset along with the
            // outputs so that an aborted operation leaves no stale state.
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            borrow_reg <= 1'b0;
            err_reg    <= 1'b0;
            cnt        <= '0;
`ifdef BCD_SUB_SIGN_MAG_EN
            neg_reg    <= 1'b0;
`endif
            diff_bcd   <= '0;
            bout       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg      <= a_bcd;
                        b_reg      <= b_bcd;
                        borrow_reg <= bin;
                        res_reg    <= '0;
                        cnt        <= '0;
                        err_reg    <= inputs_bad;
`ifdef BCD_SUB_SIGN_MAG_EN
                        neg_reg    <= 1'b0;
`endif
                        busy       <= 1'b1;
                    end
                end

                SUB: begin
                    a_reg      <= a_reg >> 4;
                    b_reg      <= b_reg >> 4;
                    borrow_reg <= digit_borrow;
                    res_reg    <= res_next;
                    cnt        <= cnt + CW'(1);
`ifdef BCD_SUB_SIGN_MAG_EN
                    // Negative: set up 0 - result for the magnitude pass.
                    if (last_digit && digit_borrow) begin
                        a_reg      <= '0;
                        b_reg      <= res_next;
                        borrow_reg <= 1'b0;
                        res_reg    <= '0;
                        cnt        <= '0;
                        neg_reg    <= 1'b1;
                    end
`endif
                end

`ifdef BCD_SUB_SIGN_MAG_EN
                NEG: begin
                    a_reg      <= a_reg >> 4;
                    b_reg      <= b_reg >> 4;
                    borrow_reg <= digit_borrow;
                    res_reg    <= res_next;
                    cnt        <= cnt + CW'(1);
                end
`endif

                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    error <= err_reg;
                    if (err_reg) begin
                        diff_bcd <= '0;
                        bout     <= 1'b0;
                    end else begin
                        diff_bcd <= res_reg;
`ifdef BCD_SUB_SIGN_MAG_EN
                        bout     <= neg_reg;
`else
                        bout     <= borrow_reg;
`endif
                    end
                end

                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
